// File: rtl/pong_graph_anim_pkg.sv
// pong_pkg: colours, game state encoding and default geometry shared by the pong pixel generator.
package pong_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, MISS_WAIT} state_t;
    localparam logic [2:0] RGB_WALL   = 3'b001;
    localparam logic [2:0] RGB_PADDLE = 3'b010;
    localparam logic [2:0] RGB_BALL   = 3'b100;
    localparam logic [2:0] RGB_BG     = 3'b110;
    localparam logic [2:0] RGB_BLANK  = 3'b000;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_WALL     = 16;
    localparam int DEF_PAD_W    = 16;
    localparam int DEF_PAD_H    = 64;
    localparam int DEF_PAD_X_L  = 32;
    localparam int DEF_PAD_X_R  = 592;
    localparam int DEF_PAD_V    = 4;
endpackage

// File: rtl/pong_paddle_ctrl.sv
// pong_paddle_ctrl: one paddle's y position with clamped per-frame stepping and its on-pixel decode.
module pong_paddle_ctrl
    import pong_pkg::*;
#(
    parameter int X      = DEF_PAD_X_R,
    parameter int W      = DEF_PAD_W,
    parameter int H      = DEF_PAD_H,
    parameter int V      = DEF_PAD_V,
    parameter int Y_MIN  = DEF_WALL,
    parameter int Y_MAX  = DEF_V_ACTIVE - DEF_WALL - DEF_PAD_H,
    parameter int Y_INIT = (DEF_V_ACTIVE - DEF_PAD_H) / 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_i,
    input  logic        up_i,
    input  logic        dn_i,
    input  logic [9:0]  pix_x_i,
    input  logic [9:0]  pix_y_i,
    output logic [10:0] y_o,
    output logic        on_o
);
    logic [10:0] y_q, y_d, px, py;

    assign px = {1'b0, pix_x_i};
    assign py = {1'b0, pix_y_i};

    // Compare before subtracting so the step can never wrap below zero.
    always_comb begin
        y_d = y_q;
        if (tick_i && up_i && !dn_i)
            y_d = (y_q < 11'(Y_MIN + V)) ? 11'(Y_MIN) : y_q - 11'(V);
        else if (tick_i && dn_i && !up_i)
            y_d = (y_q + 11'(V) > 11'(Y_MAX)) ? 11'(Y_MAX) : y_q + 11'(V);
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            y_q <= 11'(Y_INIT);
        else
            y_q <= y_d;
    end

    assign y_o  = y_q;
    assign on_o = px >= 11'(X) && px < 11'(X + W) && py >= y_q && py < y_q + 11'(H);
endmodule

// File: rtl/pong_graph_anim.sv
// pong_graph_anim: animated pong pixel generator owning ball/paddle motion, collisions and misses.
// Game state advances only on the frame tick; the colour output is registered.
module pong_graph_anim
    import pong_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int NUM_PADDLES = 1,
    parameter int WALL        = 16,
    parameter int PAD_W       = 16,
    parameter int PAD_H       = 64,
    parameter int PAD_X_L     = 32,
    parameter int PAD_X_R     = 592,
    parameter int PAD_V       = 4,
    parameter int BALL        = 16,
    parameter int BALL_V      = 2,
    parameter int MISS_FRAMES = 60
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   video_on,
    input  logic [9:0]             pix_x,
    input  logic [9:0]             pix_y,
    input  logic [NUM_PADDLES-1:0] btn_up,
    input  logic [NUM_PADDLES-1:0] btn_dn,
    input  logic                   start,
    output logic [2:0]             graph_rgb,
    output logic                   hit,
    output logic [NUM_PADDLES-1:0] miss
);
    localparam int CW = $clog2(MISS_FRAMES + 1);
    localparam logic [10:0] BX0    = 11'(H_ACTIVE / 2 - BALL / 2);
    localparam logic [10:0] BY0    = 11'(V_ACTIVE / 2 - BALL / 2);
    localparam logic [10:0] L_WALL = 11'(WALL);
    localparam logic [10:0] L_BOT  = 11'(V_ACTIVE - WALL);
    localparam logic [10:0] L_BALL = 11'(BALL);
    localparam logic [10:0] L_BV   = 11'(BALL_V);
    localparam logic [10:0] L_HA   = 11'(H_ACTIVE);
    localparam logic [10:0] L_PH   = 11'(PAD_H);
    localparam logic [10:0] RX0    = 11'(PAD_X_R);
    localparam logic [10:0] RX1    = 11'(PAD_X_R + PAD_W - 1);
    localparam logic [10:0] LX0    = 11'(PAD_X_L);
    localparam logic [10:0] LX1    = 11'(PAD_X_L + PAD_W - 1);

    logic tick;
    logic [10:0] pad_y [NUM_PADDLES];
    logic [NUM_PADDLES-1:0] pad_on;
    state_t state_q, state_d;
    logic [10:0] bx_q, bx_d, by_q, by_d, bxe, bye, px, py, pad_yl;
    logic dxn_q, dxn_d, dyn_q, dyn_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic hit_q, hit_d;
    logic [NUM_PADDLES-1:0] miss_q, miss_d;
    logic [2:0] rgb_q, rgb_d;
    logic refl_r, refl_l, lost_r, lost_l, wall_on, ball_on;

    assign tick = pix_y == 10'(V_ACTIVE + 1) && pix_x == 10'd0;

    for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_pad
        pong_paddle_ctrl #(
            .X(i == 0 ? PAD_X_R : PAD_X_L), .W(PAD_W), .H(PAD_H), .V(PAD_V),
            .Y_MIN(WALL), .Y_MAX(V_ACTIVE - WALL - PAD_H), .Y_INIT((V_ACTIVE - PAD_H) / 2)
        ) u_pad (
            .clk(clk), .reset_n(reset_n), .tick_i(tick), .up_i(btn_up[i]), .dn_i(btn_dn[i]),
            .pix_x_i(pix_x), .pix_y_i(pix_y), .y_o(pad_y[i]), .on_o(pad_on[i])
        );
    end

    // dxn/dyn are direction bits: 1 means the ball moves towards smaller coordinates.
    assign pad_yl = pad_y[NUM_PADDLES-1];
    assign bxe    = bx_q + L_BALL;
    assign bye    = by_q + L_BALL;
    assign refl_r = !dxn_q && bxe >= RX0 && bxe <= RX1 && bye > pad_y[0] && by_q < pad_y[0] + L_PH;
    assign refl_l = (NUM_PADDLES == 2)
                  ? dxn_q && bx_q >= LX0 && bx_q <= LX1 && bye > pad_yl && by_q < pad_yl + L_PH
                  : dxn_q && bx_q <= L_WALL;
    assign lost_r = bxe >= L_HA;
    assign lost_l = NUM_PADDLES == 2 && bx_q <= L_BV;

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        dxn_d   = dxn_q;
        dyn_d   = dyn_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        miss_d  = '0;
        if (tick) begin
            case (state_q)
                IDLE: state_d = start ? PLAY : IDLE;
                PLAY: begin
                    dyn_d = (by_q <= L_WALL) ? 1'b0 : (bye >= L_BOT) ? 1'b1 : dyn_q;
                    dxn_d = refl_r ? 1'b1 : refl_l ? 1'b0 : dxn_q;
                    hit_d = refl_r || (refl_l && NUM_PADDLES == 2);
                    if (!refl_r && !refl_l && (lost_r || lost_l)) begin
                        miss_d  = NUM_PADDLES'({lost_l, lost_r});
                        state_d = MISS_WAIT;
                    end
                    bx_d = dxn_d ? bx_q - L_BV : bx_q + L_BV;
                    by_d = dyn_d ? by_q - L_BV : by_q + L_BV;
                end
                MISS_WAIT: begin
                    cnt_d = (cnt_q == CW'(MISS_FRAMES - 1)) ? '0 : cnt_q + CW'(1);
                    if (cnt_q == CW'(MISS_FRAMES - 1)) begin
                        state_d = IDLE;
                        bx_d    = BX0;
                        by_d    = BY0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign px      = {1'b0, pix_x};
    assign py      = {1'b0, pix_y};
    assign wall_on = py < L_WALL || py >= L_BOT || (NUM_PADDLES == 1 && px < L_WALL);
    assign ball_on = state_q != MISS_WAIT && px >= bx_q && px < bxe && py >= by_q && py < bye;
    assign rgb_d   = !video_on ? RGB_BLANK : wall_on ? RGB_WALL : (|pad_on) ? RGB_PADDLE
                   : ball_on ? RGB_BALL : RGB_BG;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            bx_q    <= BX0;
            by_q    <= BY0;
            dxn_q   <= 1'b0;
            dyn_q   <= 1'b0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            miss_q  <= '0;
            rgb_q   <= RGB_BLANK;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            dxn_q   <= dxn_d;
            dyn_q   <= dyn_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            rgb_q   <= rgb_d;
        end
    end

    assign graph_rgb = rgb_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
endmodule

// File: tb/tb_pong_graph_anim.sv
// tb_pong_graph_anim: scoreboard bench driving frame ticks and pixel probes against a game-rule model.
module tb_pong_graph_anim;
    logic clk = 1'b0, reset_n = 1'b0, video_on = 1'b0, start = 1'b0;
    logic [9:0] pix_x = '0, pix_y = '0;
    logic [0:0] btn_up = '0, btn_dn = '0;
    logic [2:0] graph_rgb;
    logic hit;
    logic [0:0] miss;

    always #5 clk = ~clk;

    pong_graph_anim dut (
        .clk(clk), .reset_n(reset_n), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
        .btn_up(btn_up), .btn_dn(btn_dn), .start(start),
        .graph_rgb(graph_rgb), .hit(hit), .miss(miss)
    );

    typedef struct {
        int         due;
        logic [2:0] rgb;
        logic       hit;
        logic       miss;
        int         x;
        int         y;
    } exp_t;

    exp_t q[$];
    int cyc = 0, compared = 0, mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Game model: state 0 idle, 1 play, 2 waiting after a miss; signed velocities.
    int m_st, m_bx, m_by, m_dx, m_dy, m_py, m_cnt;

    task automatic m_reset();
        m_st = 0; m_bx = 312; m_by = 232; m_dx = 2; m_dy = 2; m_py = 208; m_cnt = 0;
    endtask

    function automatic logic [2:0] m_colour(input int x, input int y, input logic v);
        if (!v) return 3'b000;
        if (y < 16 || y >= 464 || x < 16) return 3'b001;
        if (x >= 592 && x < 608 && y >= m_py && y < m_py + 64) return 3'b010;
        if (m_st != 2 && x >= m_bx && x < m_bx + 16 && y >= m_by && y < m_by + 16) return 3'b100;
        return 3'b110;
    endfunction

    task automatic m_frame(input logic u, input logic d, input logic s, output logic h, output logic m);
        h = 1'b0;
        m = 1'b0;
        if (m_st == 0) begin
            if (s) m_st = 1;
        end else if (m_st == 1) begin
            if (m_by <= 16) m_dy = 2;
            else if (m_by + 16 >= 464) m_dy = -2;
            if (m_dx > 0 && m_bx + 16 >= 592 && m_bx + 16 <= 607 && m_by + 16 > m_py && m_by < m_py + 64) begin
                m_dx = -2;
                h = 1'b1;
            end else if (m_dx < 0 && m_bx <= 16) begin
                m_dx = 2;
            end else if (m_bx + 16 >= 640) begin
                m = 1'b1;
                m_st = 2;
            end
            m_bx += m_dx;
            m_by += m_dy;
        end else begin
            m_cnt++;
            if (m_cnt == 60) begin
                m_cnt = 0; m_st = 0; m_bx = 312; m_by = 232;
            end
        end
        // Paddle moves after the ball so collisions see the pre-tick paddle position.
        if (u && !d) m_py = (m_py - 4 < 16) ? 16 : m_py - 4;
        else if (d && !u) m_py = (m_py + 4 > 400) ? 400 : m_py + 4;
    endtask

    task automatic drive(input logic rv, input logic v, input int x, input int y,
                         input logic u, input logic d, input logic s);
        exp_t e;
        logic h, m;
        @(posedge clk); #1;
        reset_n = rv; video_on = v; pix_x = 10'(x); pix_y = 10'(y);
        btn_up = u; btn_dn = d; start = s;
        h = 1'b0;
        m = 1'b0;
        e.rgb = rv ? m_colour(x, y, v) : 3'b000;
        if (!rv) m_reset();
        else if (x == 0 && y == 481) m_frame(u, d, s, h, m);
        e.due = cyc + 1; e.hit = h; e.miss = m; e.x = x; e.y = y;
        q.push_back(e);
    endtask

    task automatic probe(input int x, input int y, input logic v);
        if (x < 0 || x > 639 || y < 0 || y > 479) return;
        drive(1'b1, v, x, y, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame(input logic u, input logic d, input logic s, input int n);
        drive(1'b1, 1'b0, 0, 481, u, d, s);
        for (int i = 0; i < n; i++)
            probe($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 7) != 0);
        probe(600, m_py - 1, 1'b1);
        probe(600, m_py, 1'b1);
        probe(600, m_py + 63, 1'b1);
        probe(600, m_py + 64, 1'b1);
        probe(m_bx, m_by, 1'b1);
        probe(m_bx + 15, m_by + 15, 1'b1);
        probe(m_bx - 1, m_by + 8, 1'b1);
        probe(m_bx + 16, m_by + 8, 1'b1);
    endtask

    task automatic track_frame(input int n);
        int c;
        c = (m_by + 8) - (m_py + 32);
        frame(c < -2, c > 2, 1'b0, n);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            compared++;
            if (e.due != cyc || graph_rgb !== e.rgb || hit !== e.hit || miss !== e.miss) begin
                mismatched++;
                $display("FAIL pix_out cyc=%0d pix=(%0d,%0d): got rgb=%b hit=%b miss=%b, want rgb=%b hit=%b miss=%b",
                         cyc, e.x, e.y, graph_rgb, hit, miss, e.rgb, e.hit, e.miss);
            end
        end
    end

    initial begin
        m_reset();
        drive(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
        probe(600, 240, 1'b1);
        probe(320, 240, 1'b1);
        probe(300, 100, 1'b1);
        probe(300, 100, 1'b0);
        probe(312, 232, 1'b1);
        probe(600, 208, 1'b1);
        probe(600, 207, 1'b1);
        repeat (3) frame(1'b1, 1'b0, 1'b0, 2);
        probe(600, 195, 1'b1);
        probe(600, 196, 1'b1);
        repeat (60) frame(1'b1, 1'b0, 1'b0, 1);
        probe(600, 15, 1'b1);
        probe(600, 16, 1'b1);
        probe(600, 80, 1'b1);
        repeat (5) frame(1'b1, 1'b1, 1'b0, 1);
        repeat (100) frame(1'b0, 1'b1, 1'b0, 1);
        drive(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b1, 2);
        repeat (200) track_frame(2);
        drive(1'b0, 1'b0, 0, 481, 1'b1, 1'b0, 1'b1);
        probe(320, 240, 1'b1);
        probe(600, 240, 1'b1);
        repeat (60) frame(1'b1, 1'b0, 1'b0, 1);
        frame(1'b1, 1'b0, 1'b1, 2);
        repeat (240) frame(1'b1, 1'b0, 1'b0, 2);
        repeat (300) frame($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                           $urandom_range(0, 15) == 0, 2);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d outputs still pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
